// File: rtl/wb_regfile.sv
// -----------------------------------------------------------------------------
// wb_regfile
//   Writeback end of the MEM/WB pipeline register. Selects the writeback value
//   (ALU result, load data or link address) and commits it to a 2**ADDR_W x
//   DATA_W MIPS register file. Serves the two combinational ID read ports and
//   a debug read port. Exposes the WB value/enable/address for forwarding.
//   Also counts retired (committed) writes.
//
// Configuration macro:
//   WB_BYPASS_EN  - when defined, rs/rt read ports forward the WB value in the
//                   same cycle on an address hit (write-through). The debug
//                   port is never bypassed.
//
// Ports:
//   clk, reset          rising-edge clock, asynchronous active-high reset
//   PC_i, Memdata_i,
//   AluRes_i            writeback candidates from MEM/WB
//   MemtoReg_i          00=ALU, 01=Mem, 10=PC+LINK_OFFSET, 11=ALU
//   RegWr_i, Rf_i       write enable (0 = bubble) and destination register
//   rs/rt_addr_i, _o    ID read ports (combinational)
//   wb_data_o, wb_wen_o,
//   wb_addr_o           writeback value/enable/address for the forwarding unit
//   dbg_addr_i, _o      debug read port (combinational, stored value only)
//   retire_cnt_o        number of committed writes (wraps)
// -----------------------------------------------------------------------------
module wb_regfile #(
  parameter int                 DATA_W      = 32,
  parameter int                 ADDR_W      = 5,
  parameter logic [DATA_W-1:0]  LINK_OFFSET = 32'd4,
  parameter logic [DATA_W-1:0]  SP_INIT     = 32'h0000_07FC
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] PC_i,
  input  logic [DATA_W-1:0] Memdata_i,
  input  logic [DATA_W-1:0] AluRes_i,
  input  logic [1:0]        MemtoReg_i,
  input  logic              RegWr_i,
  input  logic [ADDR_W-1:0] Rf_i,
  input  logic [ADDR_W-1:0] rs_addr_i,
  input  logic [ADDR_W-1:0] rt_addr_i,
  output logic [DATA_W-1:0] rs_data_o,
  output logic [DATA_W-1:0] rt_data_o,
  output logic [DATA_W-1:0] wb_data_o,
  output logic              wb_wen_o,
  output logic [ADDR_W-1:0] wb_addr_o,
  input  logic [ADDR_W-1:0] dbg_addr_i,
  output logic [DATA_W-1:0] dbg_data_o,
  output logic [31:0]       retire_cnt_o
);

  localparam int NREG   = 2 ** ADDR_W;
  localparam int SP_IDX = 29;

  logic [DATA_W-1:0] regs_q [NREG];
  logic [DATA_W-1:0] regs_d [NREG];
  logic [31:0]       retire_cnt_q;
  logic [31:0]       retire_cnt_d;
  logic [DATA_W-1:0] wb_data;
  logic              wb_wen;

  // Writeback select; the link sum wraps modulo 2**DATA_W by truncation.
  always_comb begin
    wb_data = AluRes_i;
    case (MemtoReg_i)
      2'b01:   wb_data = Memdata_i;
      2'b10:   wb_data = PC_i + LINK_OFFSET;
      default: wb_data = AluRes_i;
    endcase
  end

  // r0 is hardwired: a write to it is neither stored nor counted.
  assign wb_wen = RegWr_i && (Rf_i != '0);

  always_comb begin
    regs_d       = regs_q;
    retire_cnt_d = retire_cnt_q;
    if (wb_wen) begin
      regs_d[Rf_i] = wb_data;
      retire_cnt_d = retire_cnt_q + 32'd1;
    end
  end

  // Asynchronous reset wins over a write on the same edge, so that write is lost.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= (i == SP_IDX) ? SP_INIT : '0;
      end
      retire_cnt_q <= '0;
    end else begin
      regs_q       <= regs_d;
      retire_cnt_q <= retire_cnt_d;
    end
  end

`ifdef WB_BYPASS_EN
  // Write-through: an ID read of the register being written this cycle sees
  // the new value immediately. wb_wen already excludes r0.
  assign rs_data_o = (wb_wen && (rs_addr_i == Rf_i)) ? wb_data : regs_q[rs_addr_i];
  assign rt_data_o = (wb_wen && (rt_addr_i == Rf_i)) ? wb_data : regs_q[rt_addr_i];
`else
  // Stored value only; the new value becomes visible the cycle after commit.
  assign rs_data_o = regs_q[rs_addr_i];
  assign rt_data_o = regs_q[rt_addr_i];
`endif

  assign dbg_data_o   = regs_q[dbg_addr_i];
  assign wb_data_o    = wb_data;
  assign wb_wen_o     = wb_wen;
  assign wb_addr_o    = Rf_i;
  assign retire_cnt_o = retire_cnt_q;

endmodule
